// File: rtl/ca_pkg.sv
// Shared constants and word type for the rule-90/150 cellular automaton.
// Imported by the CA core and by the ECC/MAC blocks that instantiate it.
package ca_pkg;

  localparam int CA_WIDTH = 8;

  localparam logic [0:CA_WIDTH-1] CA_RULE_DEFAULT = 8'hAA;

  typedef logic [0:CA_WIDTH-1] ca_word_t;

  function automatic logic ca_next(
    input logic l,
    input logic c,
    input logic r,
    input logic rule
  );
    return l ^ (rule & c) ^ r;
  endfunction

endpackage

// File: rtl/ca_cell.sv
// One CA cell: next-state bit from left/self/right mixed bits.
// RULE_BIT = 1 selects rule 150, 0 selects rule 90.
module ca_cell
  import ca_pkg::*;
#(
  parameter logic RULE_BIT = 1'b0
) (
  input  logic left,
  input  logic self,
  input  logic right,
  output logic nxt
);

  assign nxt = ca_next(left, self, right, RULE_BIT);

endmodule

// File: rtl/ca_core.sv
// Hybrid rule-90/150 CA register: mixes `in` into the state and
// advances one generation per clock, with a null boundary.
module ca_core
  import ca_pkg::*;
#(
  parameter int                 WIDTH = CA_WIDTH,
  parameter logic [0:WIDTH-1]   RULE  = CA_RULE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:WIDTH-1] in,
  output logic [0:WIDTH-1] out
);

  logic [0:WIDTH-1] s;
  logic [0:WIDTH-1] s_nxt;
  logic [0:WIDTH+1] vp;

  // Zero pads at both ends give the null boundary without wrap.
  assign vp = {1'b0, s ^ in, 1'b0};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ca_cell #(
      .RULE_BIT (RULE[i])
    ) u_cell (
      .left  (vp[i]),
      .self  (vp[i+1]),
      .right (vp[i+2]),
      .nxt   (s_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s <= '0;
    end else begin
      s <= s_nxt;
    end
  end

  assign out = s;

  if (WIDTH < 2) begin : g_width_chk
    $error("ca_core: WIDTH must be at least 2");
  end

`ifndef SYNTHESIS
  a_reset_clears: assert property (
    @(posedge clk) reset |=> (out == '0)
  );
`endif

endmodule

// File: tb/tb_ca_core.sv
// Scoreboard bench for ca_core: driver pushes expected words,
// a posedge monitor pops and compares them.
module tb_ca_core;

  logic       clk;
  logic       reset;
  logic [7:0] in;
  logic [7:0] out;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_t;

  sb_t sb_q[$];

  int total = 0;
  int bad   = 0;

  ca_core #(
    .WIDTH (8),
    .RULE  (8'hAA)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: bit 0 is the MSB of the hex literal.
  function automatic logic [7:0] step_m(
    input logic [7:0] st,
    input logic [7:0] x
  );
    logic [0:7] v;
    logic [0:7] n;
    logic [0:7] rl;
    logic       l;
    logic       r;
    rl = 8'hAA;
    v  = st ^ x;
    for (int i = 0; i < 8; i++) begin
      l    = (i == 0) ? 1'b0 : v[i-1];
      r    = (i == 7) ? 1'b0 : v[i+1];
      n[i] = l ^ (rl[i] & v[i]) ^ r;
    end
    return n;
  endfunction

  task automatic drive(
    input logic       rst,
    input logic [7:0] x,
    input logic [7:0] exp,
    input string      name
  );
    sb_t e;
    @(negedge clk);
    reset  = rst;
    in     = x;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) begin
    sb_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (out !== e.exp) begin
        bad++;
        $display("FAIL %s: out=%h expected=%h",
                 e.name, out, e.exp);
      end
    end
  end

  logic [7:0] s_seed;
  logic [7:0] a_v;
  logic [7:0] b_v;

  initial begin
    reset  = 1'b1;
    in     = 8'h00;
    s_seed = 8'h5A;
    a_v    = 8'h3C;
    b_v    = 8'h91;

    drive(1'b1, 8'h00, 8'h00, "reset");
    for (int i = 0; i < 5; i++)
      drive(1'b0, 8'h00, 8'h00, "zero_hold");

    drive(1'b1, 8'h00, 8'h00, "reset2");
    drive(1'b0, 8'h80, 8'hC0, "imp_1");
    drive(1'b0, 8'h00, 8'h60, "imp_2");
    drive(1'b0, 8'h00, 8'hD0, "imp_3");

    drive(1'b1, 8'hFF, 8'h00, "mid_reset");
    drive(1'b0, 8'h80, 8'hC0, "after_reset");

    drive(1'b1, 8'h00, 8'h00, "reset3");
    drive(1'b0, 8'hFF, 8'h2B, "all_ones");

    drive(1'b1, 8'h00, 8'h00, "reset4");
    drive(1'b0, 8'h01, 8'h02, "boundary");
    drive(1'b1, 8'h00, 8'h00, "reset5");
    drive(1'b0, 8'h80, 8'hC0, "boundary_l");

    // Linearity: f(S, A^B) must equal f(S, A) ^ f(0, B).
    drive(1'b1, 8'h00, 8'h00, "lin_rst_ab");
    drive(1'b0, s_seed, step_m(8'h00, s_seed), "lin_s_ab");
    drive(1'b0, a_v ^ b_v,
          step_m(step_m(8'h00, s_seed), a_v) ^ step_m(8'h00, b_v),
          "lin_ab");
    drive(1'b1, 8'h00, 8'h00, "lin_rst_a");
    drive(1'b0, s_seed, step_m(8'h00, s_seed), "lin_s_a");
    drive(1'b0, a_v, step_m(step_m(8'h00, s_seed), a_v), "lin_a");
    drive(1'b1, 8'h00, 8'h00, "lin_rst_b");
    drive(1'b0, b_v, step_m(8'h00, b_v), "lin_b");

    @(negedge clk);
    in = 8'h00;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++)
      @(negedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d required=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
